halt_drain_ctrl: RTL

- Pipeline sequencing controller for the 5-stage core's halt path.
- Accepts a decoded HLT from IF/ID, freezes fetch, and tracks the halt token through ID/EX, EX/MEM and MEM/WB while respecting load-use stalls, branch flushes and memory-busy freezes.
- Drives the PC/IF-ID/pipeline write enables and bubble/flush controls.
- Asserts a sticky hlt once the HLT retires from WB.

---
 rtl/halt_drain_if.sv | 32 +++
 rtl/halt_drain_ctrl.sv | 104 ++++++++++
 2 files changed

// File: rtl/halt_drain_if.sv
// Halt/drain controller bus: hazard-unit inputs and pipeline-control outputs.
// master = core/hazard side, slave = halt_drain_ctrl.
interface halt_drain_if #(
  parameter int CNT_W = 8
);
  logic             hlt_found;
  logic             stall;
  logic             flush;
  logic             mem_busy;
  logic             pc_wen;
  logic             ifid_wen;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_wen;
  logic             hlt_in_ex;
  logic             hlt;
  logic [1:0]       state;
  logic [CNT_W-1:0] drain_cnt;
  logic             hlt_timeout;

  modport master (
    output hlt_found, stall, flush, mem_busy,
    input  pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_wen,
           hlt_in_ex, hlt, state, drain_cnt, hlt_timeout
  );

  modport slave (
    input  hlt_found, stall, flush, mem_busy,
    output pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_wen,
           hlt_in_ex, hlt, state, drain_cnt, hlt_timeout
  );
endinterface

// File: rtl/halt_drain_ctrl.sv
// Halt sequencing for the 5-stage core: freezes fetch on HLT and drains it to WB.
// Optional drain watchdog enabled by defining HLT_WATCHDOG_EN.
module halt_drain_ctrl #(
  parameter int CNT_W     = 8,
  parameter int MAX_DRAIN = 64
) (
  input  logic       clk,
  input  logic       rst,
  halt_drain_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  if (MAX_DRAIN >= (2 ** CNT_W)) begin : g_bad_max_drain
    $error("MAX_DRAIN must fit in CNT_W bits");
  end

  state_t           state_q, state_d;
  logic             tok_ex, tok_mem, tok_wb;
  logic             sticky;
  logic [CNT_W-1:0] cnt_q;
  logic             adv, accept, wd_fire;
  logic             pc_wen, ifid_wen, ifid_flush, idex_bubble, pipe_wen;

  assign adv    = !bus.mem_busy;
  assign accept = (state_q == RUN) && bus.hlt_found && !bus.stall && !bus.flush && adv;

`ifdef HLT_WATCHDOG_EN
  logic timeout_q;
  // Compare against the pre-increment count so HALTED lands the cycle after the limit.
  assign wd_fire = (state_q == DRAIN) && (cnt_q == CNT_W'(MAX_DRAIN));
  always_ff @(posedge clk) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_q | wd_fire;
  end
  assign bus.hlt_timeout = timeout_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.hlt_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_wen    = 1'b0;
    case (state_q)
      RUN: begin
        pc_wen      = adv && !bus.stall && !accept;
        ifid_wen    = adv && !bus.stall && !accept;
        ifid_flush  = bus.flush || accept;
        idex_bubble = bus.stall && adv;
        pipe_wen    = adv;
        if (accept) state_d = DRAIN;
      end
      DRAIN: begin
        // Keep NOPs flowing into IF/ID while the PC sits on the post-HLT address.
        ifid_wen   = adv;
        ifid_flush = 1'b1;
        pipe_wen   = adv;
        if (tok_wb || wd_fire) state_d = HALTED;
      end
      HALTED: begin
        ifid_wen   = adv;
        ifid_flush = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tok_ex  <= 1'b0;
      tok_mem <= 1'b0;
      tok_wb  <= 1'b0;
      sticky  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (adv) begin
        tok_ex  <= accept;
        tok_mem <= tok_ex;
        tok_wb  <= tok_mem;
      end
      sticky <= sticky | tok_wb | wd_fire;
      if (accept)
        cnt_q <= '0;
      else if ((state_q == DRAIN) && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.pc_wen      = pc_wen;
  assign bus.ifid_wen    = ifid_wen;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_bubble = idex_bubble;
  assign bus.pipe_wen    = pipe_wen;
  assign bus.hlt_in_ex   = tok_ex;
  assign bus.hlt         = tok_wb | sticky;
  assign bus.state       = state_q;
  assign bus.drain_cnt   = cnt_q;
endmodule
